// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: req/ack data-memory access, pipeline stall, MEM/WB register
// Optional ack timeout abort enabled by defining MEM_ACK_TIMEOUT_EN.
module mem_access_stage #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic [DATA_W-1:0] mem_reg2_val,
  input  logic [REG_W-1:0]  mem_fwd_reg,
  input  logic [DATA_W-1:0] mem_lb_const,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic [1:0]        mem_memtoreg,
  input  logic              mem_regwrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_fwd_reg,
  output logic              wb_regwrite,
  output logic              dmem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              access, is_load, timeout, stall_raw;
  logic [DATA_W-1:0] sel_data, done_data;

  assign access  = mem_mem_read | mem_mem_write;
  assign is_load = mem_mem_read & ~mem_mem_write;

  always_comb begin
    sel_data = (mem_memtoreg == 2'd2) ? mem_lb_const : mem_alu_out;
    done_data = sel_data;
    if (is_load && mem_memtoreg == 2'd1) done_data = dmem_rdata;
  end

`ifdef MEM_ACK_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_CNT = 4'(ACK_TIMEOUT);
  logic [3:0] cnt_q;
  logic       err_q;

  assign timeout  = (state_q == BUSY) && !dmem_ack && (cnt_q == TIMEOUT_CNT);
  assign dmem_err = err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == BUSY && !dmem_ack && !timeout) cnt_q <= cnt_q + 4'd1;
      else cnt_q <= 4'd0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout  = 1'b0;
  assign dmem_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall_raw = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack || timeout) state_d = IDLE;
        else stall_raw = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate with reset so the upstream pipeline is released the instant reset asserts.
  assign mem_stall = stall_raw & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_data     <= '0;
      wb_fwd_reg  <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (access) begin
            dmem_req    <= 1'b1;
            dmem_we     <= mem_mem_write;
            dmem_addr   <= mem_alu_out;
            dmem_wdata  <= mem_reg2_val;
            wb_regwrite <= 1'b0;
          end else begin
            wb_data     <= sel_data;
            wb_fwd_reg  <= mem_fwd_reg;
            wb_regwrite <= mem_regwrite;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            wb_data     <= done_data;
            wb_fwd_reg  <= mem_fwd_reg;
            wb_regwrite <= mem_regwrite;
          end else begin
            // Bubble while waiting; a timeout additionally drops the request.
            if (timeout) dmem_req <= 1'b0;
            wb_regwrite <= 1'b0;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed vector bench for mem_access_stage
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] mem_alu_out, mem_reg2_val, mem_lb_const, dmem_rdata;
  logic [2:0]  mem_fwd_reg;
  logic        mem_mem_read, mem_mem_write, mem_regwrite, dmem_ack;
  logic [1:0]  mem_memtoreg;
  logic        dmem_req, dmem_we, mem_stall, wb_regwrite, dmem_err;
  logic [15:0] dmem_addr, dmem_wdata, wb_data;
  logic [2:0]  wb_fwd_reg;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_stage dut (
    .clock(clock), .reset(reset),
    .mem_alu_out(mem_alu_out), .mem_reg2_val(mem_reg2_val), .mem_fwd_reg(mem_fwd_reg),
    .mem_lb_const(mem_lb_const), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wb_data(wb_data), .wb_fwd_reg(wb_fwd_reg), .wb_regwrite(wb_regwrite), .dmem_err(dmem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] alu, lb, rdata;
    logic [2:0]  fwd;
    logic [1:0]  mtr;
    logic        rw, ack;
    logic [15:0] e_data;
    logic [2:0]  e_fwd;
    logic        e_rw;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    mem_alu_out = 16'h0; mem_reg2_val = 16'h0; mem_lb_const = 16'h0; dmem_rdata = 16'h0;
    mem_fwd_reg = 3'd0; mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_memtoreg = 2'd0;
    mem_regwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    int stall_cycles;
    vecs[0] = '{16'h1234, 16'h0000, 16'h0000, 3'd3, 2'd0, 1'b1, 1'b0, 16'h1234, 3'd3, 1'b1};
    vecs[1] = '{16'h1111, 16'h00FF, 16'h0000, 3'd5, 2'd2, 1'b1, 1'b0, 16'h00FF, 3'd5, 1'b1};
    vecs[2] = '{16'h0ABC, 16'h7777, 16'hDEAD, 3'd7, 2'd1, 1'b0, 1'b1, 16'h0ABC, 3'd7, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'h0000, 3'd0, 2'd3, 1'b1, 1'b0, 16'hFFFF, 3'd0, 1'b1};
    vecs[4] = '{16'h5555, 16'h0000, 16'h0000, 3'd1, 2'd2, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b1};

    idle_inputs();
    reset = 1'b1;
    #12;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    chk("rst_wb_rw", 32'(wb_regwrite), 32'h0);
    chk("rst_err", 32'(dmem_err), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Non-access vectors, including an ignored ack in IDLE
    for (int i = 0; i < 5; i++) begin
      mem_alu_out = vecs[i].alu; mem_lb_const = vecs[i].lb; dmem_rdata = vecs[i].rdata;
      mem_fwd_reg = vecs[i].fwd; mem_memtoreg = vecs[i].mtr; mem_regwrite = vecs[i].rw;
      dmem_ack = vecs[i].ack;
      #1 chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
      step();
      chk($sformatf("v%0d_data", i), 32'(wb_data), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_fwd", i), 32'(wb_fwd_reg), 32'(vecs[i].e_fwd));
      chk($sformatf("v%0d_rw", i), 32'(wb_regwrite), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'h0);
    end
    idle_inputs();
    step();

    // Load, ack in third BUSY cycle
    mem_mem_read = 1'b1; mem_alu_out = 16'h0040; mem_memtoreg = 2'd1; mem_regwrite = 1'b1;
    mem_fwd_reg = 3'd2;
    #1 chk("ld_stall_idle", 32'(mem_stall), 32'h1);
    for (int b = 1; b <= 3; b++) begin
      step();
      chk($sformatf("ld_req_b%0d", b), 32'(dmem_req), 32'h1);
      chk($sformatf("ld_addr_b%0d", b), 32'(dmem_addr), 32'h0040);
      chk($sformatf("ld_we_b%0d", b), 32'(dmem_we), 32'h0);
      chk($sformatf("ld_bubble_b%0d", b), 32'(wb_regwrite), 32'h0);
      if (b == 3) begin
        dmem_ack = 1'b1; dmem_rdata = 16'hBEEF;
      end
      #1 chk($sformatf("ld_stall_b%0d", b), 32'(mem_stall), (b == 3) ? 32'h0 : 32'h1);
    end
    step();
    chk("ld_wb_data", 32'(wb_data), 32'hBEEF);
    chk("ld_wb_rw", 32'(wb_regwrite), 32'h1);
    chk("ld_wb_fwd", 32'(wb_fwd_reg), 32'h2);
    chk("ld_req_done", 32'(dmem_req), 32'h0);
    idle_inputs();
    step();

    // Store, ack in first BUSY cycle
    mem_mem_write = 1'b1; mem_alu_out = 16'h0010; mem_reg2_val = 16'h00AA; mem_regwrite = 1'b0;
    step();
    chk("st_req", 32'(dmem_req), 32'h1);
    chk("st_we", 32'(dmem_we), 32'h1);
    chk("st_wdata", 32'(dmem_wdata), 32'h00AA);
    dmem_ack = 1'b1;
    #1 chk("st_stall_ack", 32'(mem_stall), 32'h0);
    step();
    chk("st_wb_rw", 32'(wb_regwrite), 32'h0);
    chk("st_req_done", 32'(dmem_req), 32'h0);
    idle_inputs();
    step();

    // Read and write together behave as a store; no memory data selected
    mem_mem_read = 1'b1; mem_mem_write = 1'b1; mem_memtoreg = 2'd1; mem_alu_out = 16'h0300;
    mem_regwrite = 1'b1; mem_fwd_reg = 3'd6;
    step();
    chk("rw_we", 32'(dmem_we), 32'h1);
    dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
    step();
    chk("rw_wb_data", 32'(wb_data), 32'h0300);
    idle_inputs();
    step();

    // Reset asserted mid-BUSY, then a late ack
    mem_mem_read = 1'b1; mem_alu_out = 16'h0050; mem_memtoreg = 2'd1; mem_regwrite = 1'b1;
    step();
    chk("rb_req_before", 32'(dmem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("rb_req", 32'(dmem_req), 32'h0);
    chk("rb_stall", 32'(mem_stall), 32'h0);
    chk("rb_wb_rw", 32'(wb_regwrite), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle_inputs();
    mem_alu_out = 16'h0222; mem_memtoreg = 2'd1; mem_regwrite = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 16'h9999;
    step();
    chk("rb_late_ack_data", 32'(wb_data), 32'h0222);
    chk("rb_late_ack_req", 32'(dmem_req), 32'h0);
    idle_inputs();
    #1 chk("rb_late_ack_stall", 32'(mem_stall), 32'h0);
    step();

    // No ack: timeout abort or indefinite wait
    mem_mem_read = 1'b1; mem_alu_out = 16'h0070; mem_regwrite = 1'b1;
    stall_cycles = 0;
    for (int c = 0; c < 150; c++) begin
      #1;
      if (!mem_stall) break;
      stall_cycles++;
      @(negedge clock);
    end
`ifdef MEM_ACK_TIMEOUT_EN
    chk("to_stall_cycles", 32'(stall_cycles), 32'd16);
    step();
    mem_mem_read = 1'b0;
    chk("to_err", 32'(dmem_err), 32'h1);
    chk("to_req", 32'(dmem_req), 32'h0);
    chk("to_wb_rw", 32'(wb_regwrite), 32'h0);
    step();
    step();
    chk("to_err_sticky", 32'(dmem_err), 32'h1);
`else
    chk("to_stall_cycles", 32'(stall_cycles), 32'd150);
    chk("to_req_held", 32'(dmem_req), 32'h1);
    chk("to_err_tied", 32'(dmem_err), 32'h0);
`endif
    reset = 1'b1;
    #1 chk("final_err_cleared", 32'(dmem_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
